// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC from decode redirects,
// and holds the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int                    PC_WIDTH    = 10,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'h3F,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   PCSrc,
  input  logic [PC_WIDTH-1:0]    adderResult,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jaddress,
  input  logic                   jr,
  input  logic [PC_WIDTH-1:0]    jr_target,
  input  logic [31:0]            imem_rdata,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [31:0]            instruction,
  output logic [PC_WIDTH-1:0]    PCPlus1,
  output logic                   valid_ID,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic                vld;
  } ifid_t;

  logic [0:0]             state, state_nxt;
  logic [PC_WIDTH-1:0]    pc, pc_nxt, pc_plus1, target;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
  ifid_t                  ifid, ifid_nxt;
  logic                   redirect, is_halt;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 1'b1;
  assign redirect  = jr | jump | PCSrc;
  assign is_halt   = (imem_rdata[31:26] == HALT_OPCODE);

  // Fixed priority even though decode should only ever raise one of these.
  always_comb begin
    if (jr)        target = jr_target;
    else if (jump) target = jaddress;
    else           target = adderResult;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    ifid_nxt  = ifid;
    case (state)
      ST_RUN: begin
        if (stall) begin
          // hold everything; decode re-presents any redirect after the stall
        end else if (redirect) begin
          pc_nxt   = target;
          ifid_nxt = '0;
        end else if (is_halt) begin
          ifid_nxt  = '0;
          state_nxt = ST_HALT;
        end else begin
          ifid_nxt = '{instr: imem_rdata, pc_plus1: pc_plus1, vld: 1'b1};
          pc_nxt   = pc_plus1;
          cnt_nxt  = cnt + 1'b1;
        end
      end
      default: begin
        // Halted: keep draining IF/ID with bubbles, ignore stall and redirects.
        ifid_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
      ifid  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      ifid  <= ifid_nxt;
    end
  end

  assign instruction = ifid.instr;
  assign PCPlus1     = ifid.pc_plus1;
  assign valid_ID    = ifid.vld;
  assign halted      = (state == ST_HALT);
  assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns 0x20000000+addr, or HALT at 0x010 when enabled.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, PCSrc, jump, jr;
  logic [9:0]  adderResult, jaddress, jr_target;
  logic [31:0] imem_rdata;
  logic [9:0]  imem_addr;
  logic [31:0] instruction;
  logic [9:0]  PCPlus1;
  logic        valid_ID, halted;
  logic [31:0] fetch_count;
  logic        halt_en;
  int          n_vec = 0;
  int          n_err = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .adderResult(adderResult),
    .jump(jump), .jaddress(jaddress), .jr(jr), .jr_target(jr_target),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .instruction(instruction),
    .PCPlus1(PCPlus1), .valid_ID(valid_ID), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (halt_en && imem_addr == 10'h010) imem_rdata = 32'hFC00_0000;
    else                                 imem_rdata = 32'h2000_0000 + {22'd0, imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [9:0] pc, input logic [31:0] ins,
                        input logic [9:0] pp1, input logic v, input logic h, input logic [31:0] cnt);
    chk({tag, ".pc"},    {22'd0, imem_addr}, {22'd0, pc});
    chk({tag, ".instr"}, instruction, ins);
    chk({tag, ".pp1"},   {22'd0, PCPlus1}, {22'd0, pp1});
    chk({tag, ".vld"},   {31'd0, valid_ID}, {31'd0, v});
    chk({tag, ".halt"},  {31'd0, halted}, {31'd0, h});
    chk({tag, ".cnt"},   fetch_count, cnt);
  endtask

  initial begin
    rst = 1; stall = 0; PCSrc = 0; jump = 0; jr = 0; halt_en = 0;
    adderResult = '0; jaddress = '0; jr_target = '0;
    tick();
    chk_if("reset", 10'h000, 32'h0, 10'h000, 0, 0, 0);
    rst = 0;

    // sequential fetch
    tick(); chk_if("seq0", 10'h001, 32'h2000_0000, 10'h001, 1, 0, 1);
    tick(); chk_if("seq1", 10'h002, 32'h2000_0001, 10'h002, 1, 0, 2);
    tick(); chk_if("seq2", 10'h003, 32'h2000_0002, 10'h003, 1, 0, 3);
    tick(); tick();
    chk({"pc5"}, {22'd0, imem_addr}, 32'h5);

    // taken branch at PC=5
    PCSrc = 1; adderResult = 10'h040;
    tick(); chk_if("br_bub", 10'h040, 32'h0, 10'h000, 0, 0, 5);
    PCSrc = 0;
    tick(); chk_if("br_tgt", 10'h041, 32'h2000_0040, 10'h041, 1, 0, 6);

    // jr+jump under stall: everything holds
    jr = 1; jr_target = 10'h100; jump = 1; jaddress = 10'h200; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_if("stall", 10'h041, 32'h2000_0040, 10'h041, 1, 0, 6);
    end
    stall = 0;
    tick(); chk_if("prio", 10'h100, 32'h0, 10'h000, 0, 0, 6);
    jr = 0; jump = 0;
    tick(); chk_if("jr_tgt", 10'h101, 32'h2000_0100, 10'h101, 1, 0, 7);

    // reset mid-stall with valid IF/ID
    stall = 1; rst = 1;
    tick(); chk_if("rst_stall", 10'h000, 32'h0, 10'h000, 0, 0, 0);
    stall = 0; rst = 0;

    // PC wrap
    jump = 1; jaddress = 10'h3FF;
    tick(); chk_if("to3ff", 10'h3FF, 32'h0, 10'h000, 0, 0, 0);
    jump = 0;
    tick(); chk_if("wrap", 10'h000, 32'h2000_03FF, 10'h000, 1, 0, 1);

    // HALT word squashed by a concurrent jump
    halt_en = 1; jump = 1; jaddress = 10'h010;
    tick(); chk({"to010"}, {22'd0, imem_addr}, 32'h010);
    jaddress = 10'h020;
    tick(); chk_if("halt_squash", 10'h020, 32'h0, 10'h000, 0, 0, 1);
    jaddress = 10'h010;
    tick(); jump = 0;

    // real HALT, then redirect/stall pulses are ignored
    tick(); chk_if("halt", 10'h010, 32'h0, 10'h000, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      PCSrc = i[0]; jump = ~i[0]; stall = i[1];
      adderResult = 10'h055; jaddress = 10'h066;
      tick(); chk_if("halt_hold", 10'h010, 32'h0, 10'h000, 0, 1, 1);
    end
    PCSrc = 0; jump = 0; stall = 0;

    // reset while halted
    rst = 1;
    tick(); chk_if("rst_halt", 10'h000, 32'h0, 10'h000, 0, 0, 0);
    rst = 0; halt_en = 0;
    tick(); chk_if("post_rst", 10'h001, 32'h2000_0000, 10'h001, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
